// File: rtl/adder_cla_pipe.sv
// rtl/adder_cla_pipe.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control
module adder_cla_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // Chunk-local lookahead: every carry is a flat sum-of-products of g/p
    // and the chunk carry-in, not a ripple chain. Returns {carry_out, sum}.
    function automatic logic [CHUNK:0] cla(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             t;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & p[m];
                end
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;

    // One global advance enable: the pipe only moves when the output slot frees up.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    // Subtraction becomes a + ~b + ~cin, so every stage is a plain adder.
    assign b_eff    = b ^ {WIDTH{sub}};

    genvar k;
    for (k = 0; k < STAGES; k++) begin : stg
        localparam int SW = (k + 1) * CHUNK;   // finished sum bits after this stage
        localparam int IW = WIDTH - k * CHUNK; // operand bits still to process at entry

        logic [IW-1:0]    ain;
        logic [IW-1:0]    bin;
        logic             ci;
        logic             v_in;
        logic [SW-1:0]    s_next;
        logic [CHUNK:0]   r;
        logic [CHUNK-1:0] x;
        logic [CHUNK-1:0] y;

        logic             v_q;
        logic             c_q;
        logic [SW-1:0]    s_q;

        if (k == 0) begin : g_in
            assign ain    = a;
            assign bin    = b_eff;
            assign ci     = cin ^ sub;
            assign v_in   = in_valid;
            assign s_next = r[CHUNK-1:0];
        end else begin : g_mid
            assign ain    = stg[k-1].g_skew.a_q;
            assign bin    = stg[k-1].g_skew.b_q;
            assign ci     = stg[k-1].c_q;
            assign v_in   = stg[k-1].v_q;
            assign s_next = {r[CHUNK-1:0], stg[k-1].s_q};
        end

        assign x = ain[CHUNK-1:0];
        assign y = bin[CHUNK-1:0];
        assign r = cla(x, y, ci);

        // Stage register: valid slot, chunk carry and accumulated sum bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= r[CHUNK];
                s_q <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [IW-CHUNK-1:0] a_q;
            logic [IW-CHUNK-1:0] b_q;

            // Skew registers: carry only the chunks later stages still need.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= ain[IW-1:CHUNK];
                    b_q <= bin[IW-1:CHUNK];
                end
            end
        end else begin : g_last
            logic cm_q;

            // Carry into the MSB, recovered from the MSB sum and propagate bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cm_q <= 1'b0;
                end else if (en) begin
                    cm_q <= r[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
                end
            end
        end
    end

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].s_q;
    assign cout      = stg[STAGES-1].c_q;
    assign ovf       = stg[STAGES-1].c_q ^ stg[STAGES-1].g_last.cm_q;

endmodule

// File: tb/tb_adder_cla_pipe.sv
// tb/tb_adder_cla_pipe.sv - self-checking bench for adder_cla_pipe
module tb_adder_cla_pipe;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    adder_cla_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    bit   acc_log[int];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   drained  = 0;
    bit   lat_chk  = 0;
    bit   stall_chk = 0;
    bit   vpat_chk = 0;
    bit   last_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic in W+2 bits, unsigned and signed.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t               e;
        logic [W+1:0]        u;
        logic signed [W+1:0] sx;
        logic signed [W+1:0] sy;
        logic signed [W+1:0] sr;
        sx = {{2{x[W-1]}}, x};
        sy = {{2{y[W-1]}}, y};
        if (!s) begin
            u      = {2'b00, x} + {2'b00, y} + (W+2)'(ci);
            sr     = sx + sy + $signed((W+2)'(ci));
            e.cout = u[W];
        end else begin
            u      = {2'b00, x} - {2'b00, y} - (W+2)'(ci);
            sr     = sx - sy - $signed((W+2)'(ci));
            e.cout = ~u[W+1];
        end
        e.sum = u[W-1:0];
        e.ovf = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom());
        endcase
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        pend     = model(x, y, ci, s);
    endtask

    task automatic drive_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                             input logic s, input logic [W-1:0] es, input logic ec,
                             input logic eo);
        drive(1'b1, x, y, ci, s);
        pend.sum  = es;
        pend.cout = ec;
        pend.ovf  = eo;
    endtask

    // One clock: sample handshakes at the falling edge, score, then advance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (stall_chk) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            if (q.size() > 0) begin
                chk("stall_sum", 64'(sum), 64'(q[0].sum));
                chk("stall_cout", 64'(cout), 64'(q[0].cout));
                chk("stall_ovf", 64'(ovf), 64'(q[0].ovf));
            end
        end
        if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'd0);
        if (vpat_chk) chk("valid_pattern", 64'(out_valid), acc_log.exists(cyc - S) ? 64'd1 : 64'd0);
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            drained++;
            chk("sum", 64'(sum), 64'(e.sum));
            chk("cout", 64'(cout), 64'(e.cout));
            chk("ovf", 64'(ovf), 64'(e.ovf));
            if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(S));
        end
        if (last_acc) begin
            pend.cyc = cyc;
            q.push_back(pend);
            acc_log[cyc] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int i;
        int n;
        int d0;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed corner cases, back to back, latency checked.
        lat_chk = 1;
        drive_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
        drive_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); tick();
        drive_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); tick();
        drive_exp(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0); tick();
        drive_exp(16'h1234, 16'h1111, 1'b1, 1'b1, 16'h0122, 1'b1, 1'b0); tick();
        drive_exp(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        repeat (S + 2) tick();
        chk("directed_drained", 64'(q.size()), 64'd0);

        // Eight streamed ops with a three-cycle output stall in the middle.
        lat_chk = 0;
        d0 = drained;
        i = 0;
        n = 0;
        while (i < 8 && n < 100) begin
            out_ready = !(n >= 6 && n < 9);
            stall_chk = (n >= 6 && n < 9);
            drive(1'b1, W'(i), W'(256 * i), 1'b0, 1'b0);
            tick();
            if (last_acc) i++;
            n++;
        end
        stall_chk = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (S + 2) tick();
        chk("stream_count", 64'(drained - d0), 64'd8);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Reset with three ops in flight.
        repeat (3) begin
            drive(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_sum", 64'(sum), 64'd0);
        chk("midreset_cout", 64'(cout), 64'd0);
        chk("midreset_ovf", 64'(ovf), 64'd0);
        q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (S + 2) tick();
        lat_chk = 1;
        drive_exp(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (S + 1) tick();
        chk("postreset_drained", 64'(q.size()), 64'd0);

        // Bubble pattern 1,0,0,1,1 must reappear S cycles later.
        vpat_chk = 1;
        for (int j = 0; j < 5; j++) begin
            drive(pat[j], rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        in_valid = 1'b0;
        repeat (S + 2) tick();
        vpat_chk = 0;
        lat_chk  = 0;

        // Random traffic with random backpressure.
        for (int r = 0; r < 3000; r++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 3) != 0, rnd(), rnd(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
